// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: op encodings, state enum, width default.
package mem_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_ALU = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_LC  = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_e;

    // True for ops that need a data-memory transaction.
    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access-timeout counter: clear, increment, saturate at TIMEOUT, terminal-count flag.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CW'(TIMEOUT));

    // Next count: clear wins, otherwise count up and hold at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: data-memory request/ack sequencing, write-back
// bundle, upstream stall and sticky timeout error.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        mem_op,
    input  logic [DATA_W-1:0] mem_alu_out,
    input  logic [DATA_W-1:0] mem_reg2_val,
    input  logic [2:0]        mem_fwd_reg,
    input  logic [DATA_W-1:0] mem_lb_const,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              stall,
    output logic              wb_valid,
    output logic [2:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    mem_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        dst_q, dst_d;
    logic              wbv_q, wbv_d;
    logic [2:0]        wbreg_q, wbreg_d;
    logic [DATA_W-1:0] wbdata_q, wbdata_d;
    logic              err_q, err_d;
    logic              ctr_clear, ctr_inc, ctr_tc;

    assign ctr_clear = (state_q == IDLE) && is_mem_op(mem_op);
    assign ctr_inc   = (state_q == ACCESS) && !dm_ack;

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clock  (clock),
        .reset  (reset),
        .clear_i(ctr_clear),
        .inc_i  (ctr_inc),
        .tc_o   (ctr_tc)
    );

    // Stall covers the issuing IDLE cycle and every ACCESS cycle; never during reset.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            stall = ((state_q == IDLE) && is_mem_op(mem_op)) || (state_q == ACCESS);
        end
    end

    // Next-state and registered-output logic; write-back strobe defaults low.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        dst_d    = dst_q;
        wbv_d    = 1'b0;
        wbreg_d  = wbreg_q;
        wbdata_d = wbdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                unique case (mem_op_e'(mem_op))
                    OP_ALU: begin
                        wbv_d    = 1'b1;
                        wbdata_d = mem_alu_out;
                        wbreg_d  = mem_fwd_reg;
                    end
                    OP_LC: begin
                        wbv_d    = 1'b1;
                        wbdata_d = mem_lb_const;
                        wbreg_d  = mem_fwd_reg;
                    end
                    OP_LW, OP_SW: begin
                        addr_d  = mem_alu_out;
                        wdata_d = mem_reg2_val;
                        we_d    = (mem_op == OP_SW);
                        dst_d   = mem_fwd_reg;
                        req_d   = 1'b1;
                        state_d = ACCESS;
                    end
                endcase
            end
            ACCESS: begin
                // An ack on the same edge as the timeout takes priority.
                if (dm_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        wbv_d    = 1'b1;
                        wbdata_d = dm_rdata;
                        wbreg_d  = dst_q;
                    end
                end else if (ctr_tc) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dst_q    <= '0;
            wbv_q    <= 1'b0;
            wbreg_q  <= '0;
            wbdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            dst_q    <= dst_d;
            wbv_q    <= wbv_d;
            wbreg_q  <= wbreg_d;
            wbdata_q <= wbdata_d;
            err_q    <= err_d;
        end
    end

    assign dm_req   = req_q;
    assign dm_we    = we_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign wb_valid = wbv_q;
    assign wb_reg   = wbreg_q;
    assign wb_data  = wbdata_q;
    assign mem_err  = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_stage_ctrl;
    import mem_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned TO = 15;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mem_op = 2'b00;
    logic [DW-1:0] mem_alu_out = '0, mem_reg2_val = '0, mem_lb_const = '0, dm_rdata = '0;
    logic [2:0]    mem_fwd_reg = '0;
    logic          dm_ack = 1'b0;
    logic          dm_req, dm_we, stall, wb_valid, mem_err;
    logic [DW-1:0] dm_addr, dm_wdata, wb_data;
    logic [2:0]    wb_reg;

    mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .mem_op(mem_op), .mem_alu_out(mem_alu_out),
        .mem_reg2_val(mem_reg2_val), .mem_fwd_reg(mem_fwd_reg), .mem_lb_const(mem_lb_const),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an access is "outstanding" while the request is up;
    // req_age counts cycles the request has been visible; one settle cycle follows.
    bit            m_live = 0;
    bit            m_outstanding = 0, m_settle = 0;
    int            req_age = 0;
    logic          m_req = 0, m_we = 0, m_wbv = 0, m_err = 0;
    logic [DW-1:0] m_addr = '0, m_wdata = '0, m_wbdata = '0;
    logic [2:0]    m_dst = '0, m_wbreg = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_live = 1; m_outstanding = 0; m_settle = 0; req_age = 0;
            m_req = 0; m_we = 0; m_wbv = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_wbdata = '0; m_dst = '0; m_wbreg = '0;
        end else if (m_live) begin
            m_wbv = 0;
            if (m_settle) begin
                m_settle = 0;
            end else if (m_outstanding) begin
                if (dm_ack) begin
                    m_outstanding = 0; m_req = 0; m_settle = 1;
                    if (!m_we) begin
                        m_wbv = 1; m_wbdata = dm_rdata; m_wbreg = m_dst;
                    end
                end else if (req_age == TO + 1) begin
                    m_outstanding = 0; m_req = 0; m_settle = 1; m_err = 1;
                end else begin
                    req_age++;
                end
            end else if (mem_op == OP_LW || mem_op == OP_SW) begin
                m_outstanding = 1; m_req = 1; req_age = 1;
                m_addr = mem_alu_out; m_wdata = mem_reg2_val;
                m_we = (mem_op == OP_SW); m_dst = mem_fwd_reg;
            end else begin
                m_wbv = 1; m_wbreg = mem_fwd_reg;
                m_wbdata = (mem_op == OP_LC) ? mem_lb_const : mem_alu_out;
            end
        end
    end

    int stall_cnt = 0, req_cnt = 0, wbv_cnt = 0;

    // Per-cycle compare against the model, plus activity counters.
    always @(negedge clock) begin
        if (m_live) begin
            logic exp_stall;
            exp_stall = !reset && (m_outstanding ||
                        (!m_settle && (mem_op == OP_LW || mem_op == OP_SW)));
            check("stall",    32'(stall),    32'(exp_stall));
            check("dm_req",   32'(dm_req),   32'(m_req));
            check("dm_we",    32'(dm_we),    32'(m_we));
            check("dm_addr",  32'(dm_addr),  32'(m_addr));
            check("dm_wdata", 32'(dm_wdata), 32'(m_wdata));
            check("wb_valid", 32'(wb_valid), 32'(m_wbv));
            check("wb_reg",   32'(wb_reg),   32'(m_wbreg));
            check("wb_data",  32'(wb_data),  32'(m_wbdata));
            check("mem_err",  32'(mem_err),  32'(m_err));
        end
        if (stall === 1'b1)    stall_cnt++;
        if (dm_req === 1'b1)   req_cnt++;
        if (wb_valid === 1'b1) wbv_cnt++;
    end

    task automatic filler();
        mem_op = OP_ALU; mem_alu_out = '0; mem_fwd_reg = '0;
    endtask

    // Issues a memory op; `waits` no-ack ACCESS cycles, then an ack cycle if do_ack.
    task automatic mem_access(input logic [1:0] op, input logic [DW-1:0] addr,
                              input logic [DW-1:0] wd, input logic [2:0] rg,
                              input int waits, input bit do_ack, input logic [DW-1:0] rd,
                              output int n_stall, output int n_req, output int n_wbv);
        int s0, r0, w0;
        @(posedge clock); #1;
        mem_op = op; mem_alu_out = addr; mem_reg2_val = wd; mem_fwd_reg = rg;
        s0 = stall_cnt;
        @(posedge clock); #1;
        r0 = req_cnt; w0 = wbv_cnt;
        repeat (waits) begin
            @(posedge clock); #1;
        end
        if (do_ack) begin
            dm_ack = 1'b1; dm_rdata = rd;
            @(posedge clock); #1;
            dm_ack = 1'b0;
        end
        filler();
        @(posedge clock); #1;
        n_stall = stall_cnt - s0;
        n_req   = req_cnt - r0;
        n_wbv   = wbv_cnt - w0;
    endtask

    initial begin
        int ns, nr, nw;
        filler();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_dm_req", 32'(dm_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        // ALU pass-through
        @(posedge clock); #1;
        mem_op = OP_ALU; mem_alu_out = 16'h1234; mem_fwd_reg = 3'd5;
        @(posedge clock); #1;
        filler();
        @(negedge clock);
        check("alu_wb_valid", 32'(wb_valid), 32'd1);
        check("alu_wb_data", 32'(wb_data), 32'h1234);
        check("alu_wb_reg", 32'(wb_reg), 32'd5);

        // Load constant must select the constant, not the ALU value
        @(posedge clock); #1;
        mem_op = OP_LC; mem_lb_const = 16'h00AB; mem_alu_out = 16'hFFFF; mem_fwd_reg = 3'd2;
        @(posedge clock); #1;
        filler();
        @(negedge clock);
        check("lc_wb_data", 32'(wb_data), 32'h00AB);
        check("lc_wb_reg", 32'(wb_reg), 32'd2);
        check("lc_dm_req", 32'(dm_req), 32'd0);

        // Load with two wait cycles
        mem_access(OP_LW, 16'h0040, 16'h1111, 3'd3, 2, 1'b1, 16'hBEEF, ns, nr, nw);
        check("lw_stall_cycles", 32'(ns), 32'd4);
        check("lw_req_cycles", 32'(nr), 32'd3);
        check("lw_wbv_pulses", 32'(nw), 32'd1);
        check("lw_dm_we", 32'(dm_we), 32'd0);
        check("lw_wb_data", 32'(wb_data), 32'hBEEF);
        check("lw_wb_reg", 32'(wb_reg), 32'd3);

        // Store with immediate ack
        mem_access(OP_SW, 16'h0010, 16'h5A5A, 3'd7, 0, 1'b1, 16'hDEAD, ns, nr, nw);
        check("sw_stall_cycles", 32'(ns), 32'd2);
        check("sw_req_cycles", 32'(nr), 32'd1);
        check("sw_wbv_pulses", 32'(nw), 32'd0);
        check("sw_dm_we", 32'(dm_we), 32'd1);
        check("sw_dm_wdata", 32'(dm_wdata), 32'h5A5A);
        check("sw_dm_addr", 32'(dm_addr), 32'h0010);

        // Ack arrives on the very edge the timeout would fire: ack wins
        mem_access(OP_LW, 16'h0050, 16'h0000, 3'd1, TO, 1'b1, 16'h0C0C, ns, nr, nw);
        check("edge_req_cycles", 32'(nr), 32'(TO + 1));
        check("edge_wbv_pulses", 32'(nw), 32'd1);
        check("edge_wb_data", 32'(wb_data), 32'h0C0C);
        check("edge_mem_err", 32'(mem_err), 32'd0);

        // No ack at all: timeout
        mem_access(OP_LW, 16'h0080, 16'h0000, 3'd4, TO + 1, 1'b0, 16'h0000, ns, nr, nw);
        check("to_req_cycles", 32'(nr), 32'(TO + 1));
        check("to_stall_cycles", 32'(ns), 32'(TO + 2));
        check("to_wbv_pulses", 32'(nw), 32'd0);
        check("to_mem_err", 32'(mem_err), 32'd1);
        repeat (3) @(posedge clock);
        #1 check("to_mem_err_sticky", 32'(mem_err), 32'd1);

        // Following access still completes
        mem_access(OP_LW, 16'h0022, 16'h0000, 3'd6, 0, 1'b1, 16'h7777, ns, nr, nw);
        check("after_to_wbv", 32'(nw), 32'd1);
        check("after_to_wb_data", 32'(wb_data), 32'h7777);
        check("after_to_mem_err", 32'(mem_err), 32'd1);

        // Reset in the middle of an access
        @(posedge clock); #1;
        mem_op = OP_LW; mem_alu_out = 16'h0300; mem_fwd_reg = 3'd1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        check("rst_mid_dm_req", 32'(dm_req), 32'd0);
        check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mid_mem_err", 32'(mem_err), 32'd0);
        reset = 1'b0;
        mem_op = OP_ALU; mem_alu_out = 16'h4444; mem_fwd_reg = 3'd1;
        dm_ack = 1'b1; dm_rdata = 16'h9999;
        @(posedge clock); #1;
        dm_ack = 1'b0;
        filler();
        check("late_ack_wb_data", 32'(wb_data), 32'h4444);
        check("late_ack_dm_req", 32'(dm_req), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
